aes_block_assembler: RTL and testbench
======================================

// Module: aes_block_assembler
// PURPOSE
//   Downstream of the serial-to-parallel byte deserialiser: packs 16 bytes, each marked by a
//   one-cycle DataValid strobe, into one 128-bit AES state block. It offers the block to the
//   AES core over a valid/ready handshake. Double-buffered, so the next block can fill while
//   the previous block waits for the core.
// PARAMETERS
//   NBYTES      16  bytes per block; output width is 8*NBYTES
//   FIRST_MSB   1   1: first byte received -> blk_out[8*NBYTES-1 -:8] (FIPS-197 order); 0: -> blk_out[7:0]
// PORTS
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-low reset
//   in_byte    in   8    byte from deserialiser (its out)
//   in_valid   in   1    byte strobe (deserialiser DataValid); one byte accepted per cycle it is high
//   clear      in   1    synchronous flush of the partially filled block
//   blk_out    out  128  assembled block; stable while blk_valid=1
//   blk_valid  out  1    output buffer holds a complete block
//   blk_ready  in   1    AES core accepts the block when blk_valid&&blk_ready
//   byte_cnt   out  5    bytes held in the fill buffer, 0..NBYTES-1
//   overflow   out  1    one-cycle pulse: a completing byte was dropped because the output buffer was full
// BEHAVIOUR
//   Reset (rst=0, async): fill buffer=0, byte_cnt=0, blk_out=0, blk_valid=0, overflow=0, out_state=EMPTY.
//   Fill side:
//   - in_valid=1 and byte_cnt<NBYTES-1: store in_byte at slot byte_cnt; byte_cnt+1.
//   - in_valid=1 and byte_cnt=NBYTES-1: this is the completing byte.
//     - output EMPTY, or FULL with blk_ready=1 in the same cycle: the buffer plus this byte move
//       to blk_out at that edge; byte_cnt wraps to 0; blk_valid=1 after the edge (latency 1 clk
//       from the 16th strobe). Back-to-back blocks with continuous ready lose no bytes.
//     - output FULL and blk_ready=0: byte dropped; byte_cnt stays 15; fill buffer unchanged;
//       overflow=1 for that one cycle.
//   - clear=1: byte_cnt=0 and fill buffer zeroed; it overrides in_valid in the same cycle.
//     clear does not touch blk_out/blk_valid.
//   Output FSM (out_state):
//   - EMPTY -> FULL on the completing byte.
//   - FULL -> EMPTY on blk_ready=1 with no completing byte in that cycle.
//   - FULL -> FULL on blk_ready=1 with a completing byte; blk_out reloads.
//   - FULL: blk_ready=0 holds blk_out and blk_valid stable; blk_out never changes while blk_valid=1 && !blk_ready.
//   blk_valid == (out_state==FULL). blk_ready is ignored while EMPTY.
//   Slot mapping, FIRST_MSB=1: byte k -> blk_out[127-8k -: 8]. FIRST_MSB=0: byte k -> blk_out[8k +: 8].
//   in_valid is sampled only on rising edges. A strobe wider than one cycle counts as one byte per cycle.
//   Reset asserted mid-block: all state cleared immediately; a partial block is discarded with no overflow pulse.
// TESTING
//   1 Reset: rst=0 mid-fill -> blk_valid=0, byte_cnt=0, blk_out=0 without waiting for a clk edge.
//   2 Feed 00,11,22..FF (16 strobes, gaps of 3 clk), blk_ready=1 -> one cycle after 16th strobe
//     blk_valid=1, blk_out=128'h00112233445566778899AABBCCDDEEFF; EMPTY the next edge.
//   3 FIRST_MSB=0, same bytes -> blk_out=128'hFFEEDDCCBBAA99887766554433221100.
//   4 Two blocks (A: all 8'h15, B: all 8'hC8) back-to-back every cycle, blk_ready=0 -> block A
//     held; 16th byte of B dropped, overflow pulses once, byte_cnt=15. Raise blk_ready -> A
//     accepted. Resend byte -> blk_out=all C8.
//   5 blk_ready=1 in the same cycle as block B completes while A is valid -> blk_valid stays 1,
//     blk_out switches to B at that edge, no overflow.
//   6 After 7 bytes assert clear with in_valid=1 -> byte_cnt=0. The next 16 bytes form a clean
//     block; any held blk_out is unaffected.

Source files
------------

// File: rtl/aes_block_assembler_if.sv
//------------------------------------------------------------------------------
// Module  : aes_block_assembler_if
// Brief   : Byte-in / block-out bus between the deserialiser, the block
//           assembler and the AES core.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface aes_block_assembler_if #(
    parameter int NBYTES = 16
);
    localparam int CW = $clog2(NBYTES) + 1;

    logic [7:0]          in_byte;
    logic                in_valid;
    logic                clear;
    logic [8*NBYTES-1:0] blk_out;
    logic                blk_valid;
    logic                blk_ready;
    logic [CW-1:0]       byte_cnt;
    logic                overflow;

    modport slave (
        input  in_byte, in_valid, clear, blk_ready,
        output blk_out, blk_valid, byte_cnt, overflow
    );

    modport master (
        output in_byte, in_valid, clear, blk_ready,
        input  blk_out, blk_valid, byte_cnt, overflow
    );
endinterface

`default_nettype wire

// File: rtl/aes_block_assembler.sv
//------------------------------------------------------------------------------
// Module  : aes_block_assembler
// Brief   : Packs NBYTES strobed bytes into one AES state block, double
//           buffered behind a valid/ready handshake to the AES core.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_block_assembler #(
    parameter int NBYTES    = 16,
    parameter bit FIRST_MSB = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    aes_block_assembler_if.slave  bus
);
    localparam int             CW     = $clog2(NBYTES) + 1;
    localparam int             BW     = 8 * NBYTES;
    localparam logic [CW-1:0]  C_LAST = CW'(NBYTES - 1);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BW-1:0]   r_fill;
    logic [CW-1:0]   r_cnt;
    logic [BW-1:0]   r_blk;
    logic            r_ovf;

    logic            w_complete;
    logic            w_load;
    logic            w_drop;
    logic [BW-1:0]   w_block;

    // Bit offset of byte slot k within the block.
    function automatic int slot_lo(input logic [CW-1:0] k);
        if (FIRST_MSB)
            return 8 * (NBYTES - 1 - int'(k));
        else
            return 8 * int'(k);
    endfunction

    assign w_complete = bus.in_valid && !bus.clear && (r_cnt == C_LAST);
    assign w_load     = w_complete && ((r_state == S_EMPTY) || bus.blk_ready);
    assign w_drop     = w_complete && !w_load;

    // The completing byte bypasses the fill buffer straight into the block.
    always_comb begin
        w_block = r_fill;
        w_block[slot_lo(C_LAST) +: 8] = bus.in_byte;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_load) w_state_nxt = S_FULL;
            S_FULL:  if (bus.blk_ready && !w_load) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill <= '0;
            r_cnt  <= '0;
            r_blk  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_ovf <= w_drop;
            if (w_load)
                r_blk <= w_block;
            if (bus.clear) begin
                r_fill <= '0;
                r_cnt  <= '0;
            end else if (bus.in_valid) begin
                if (r_cnt != C_LAST) begin
                    r_fill[slot_lo(r_cnt) +: 8] <= bus.in_byte;
                    r_cnt                       <= r_cnt + 1'b1;
                end else if (w_load) begin
                    r_fill <= '0;
                    r_cnt  <= '0;
                end
            end
        end
    end

    assign bus.blk_out   = r_blk;
    assign bus.blk_valid = (r_state == S_FULL);
    assign bus.byte_cnt  = r_cnt;
    assign bus.overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_aes_block_assembler.sv
//------------------------------------------------------------------------------
// Module  : tb_aes_block_assembler
// Brief   : Self-checking bench for aes_block_assembler, both byte orders.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_block_assembler;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_block_assembler_if #(.NBYTES(16)) bus0 ();
    aes_block_assembler_if #(.NBYTES(16)) bus1 ();

    aes_block_assembler #(.NBYTES(16), .FIRST_MSB(1'b1)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    aes_block_assembler #(.NBYTES(16), .FIRST_MSB(1'b0)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    assign bus1.in_byte   = bus0.in_byte;
    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.clear     = bus0.clear;
    assign bus1.blk_ready = bus0.blk_ready;

    typedef struct {
        logic [7:0]   base;
        logic [7:0]   step;
        int           gap;
        logic [127:0] exp_msb;
        logic [127:0] exp_lsb;
    } vec_t;

    vec_t           vecs [4];
    logic [127:0]   sb [$];
    int             checks   = 0;
    int             failures = 0;
    int             ovf_seen = 0;

    logic           prev_valid = 1'b0;
    logic           prev_ready = 1'b0;
    logic [127:0]   prev_out   = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a block is "new" when valid rises or follows a handshake.
    logic [127:0] mon_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (bus0.overflow) ovf_seen++;
            if (prev_valid && !prev_ready)
                chk("hold_stable", {bus0.blk_valid, bus0.blk_out}, {1'b1, prev_out});
            if (bus0.blk_valid && (!prev_valid || prev_ready)) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_block: got %h expected none", bus0.blk_out);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("sb_block", bus0.blk_out, mon_exp);
                end
            end
            prev_valid = bus0.blk_valid;
            prev_ready = bus0.blk_ready;
            prev_out   = bus0.blk_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus0.in_valid = 1'b1;
        bus0.in_byte  = b;
        tick();
        bus0.in_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] base, input logic [7:0] step,
                              input int first, input int last, input int gap);
        for (int k = first; k <= last; k++) begin
            send_byte(base + step * 8'(k));
            if (k < last)
                repeat (gap) tick();
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h11, 3, 128'h00112233445566778899AABBCCDDEEFF,
                                     128'hFFEEDDCCBBAA99887766554433221100};
        vecs[1] = '{8'h01, 8'h01, 0, 128'h0102030405060708090A0B0C0D0E0F10,
                                     128'h100F0E0D0C0B0A090807060504030201};
        vecs[2] = '{8'h15, 8'h00, 1, {16{8'h15}}, {16{8'h15}}};
        vecs[3] = '{8'hF0, 8'h01, 2, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF,
                                     128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0};

        bus0.in_byte   = 8'h00;
        bus0.in_valid  = 1'b0;
        bus0.clear     = 1'b0;
        bus0.blk_ready = 1'b0;
        repeat (2) tick();
        chk("rst_valid", 128'(bus0.blk_valid), 128'd0);
        chk("rst_cnt",   128'(bus0.byte_cnt),  128'd0);
        chk("rst_out",   bus0.blk_out,         128'd0);
        chk("rst_ovf",   128'(bus0.overflow),  128'd0);
        rst_n = 1'b1;
        tick();

        // Table: one block per record with ready held high.
        bus0.blk_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            sb.push_back(vecs[v].exp_msb);
            send_bytes(vecs[v].base, vecs[v].step, 0, 15, vecs[v].gap);
            chk("tbl_valid",   128'(bus0.blk_valid), 128'd1);
            chk("tbl_lsb_out", bus1.blk_out,         vecs[v].exp_lsb);
            chk("tbl_cnt",     128'(bus0.byte_cnt),  128'd0);
            tick();
            chk("tbl_empty",   128'(bus0.blk_valid), 128'd0);
            wait_drain();
        end

        // Overflow: A held, B's completing byte dropped, then resent.
        bus0.blk_ready = 1'b0;
        sb.push_back({16{8'h15}});
        send_bytes(8'h15, 8'h00, 0, 15, 0);
        send_bytes(8'hC8, 8'h00, 0, 14, 0);
        chk("ovf_cnt15", 128'(bus0.byte_cnt), 128'd15);
        send_byte(8'hC8);
        chk("ovf_pulse", 128'(bus0.overflow), 128'd1);
        chk("ovf_cnt",   128'(bus0.byte_cnt), 128'd15);
        chk("ovf_hold",  bus0.blk_out, {16{8'h15}});
        tick();
        chk("ovf_once",  128'(bus0.overflow), 128'd0);
        bus0.blk_ready = 1'b1;
        tick();
        chk("ovf_accepted", 128'(bus0.blk_valid), 128'd0);
        sb.push_back({16{8'hC8}});
        send_byte(8'hC8);
        chk("ovf_resend", bus0.blk_out, {16{8'hC8}});
        tick();
        chk("ovf_drain", 128'(bus0.blk_valid), 128'd0);
        wait_drain();

        // Same-cycle handshake and reload.
        bus0.blk_ready = 1'b0;
        sb.push_back({16{8'h3C}});
        send_bytes(8'h3C, 8'h00, 0, 15, 0);
        send_bytes(8'hA5, 8'h00, 0, 14, 0);
        bus0.blk_ready = 1'b1;
        sb.push_back({16{8'hA5}});
        send_byte(8'hA5);
        chk("swap_valid", 128'(bus0.blk_valid), 128'd1);
        chk("swap_out",   bus0.blk_out, {16{8'hA5}});
        chk("swap_ovf",   128'(bus0.overflow), 128'd0);
        tick();
        chk("swap_drain", 128'(bus0.blk_valid), 128'd0);
        wait_drain();

        // Clear mid-fill overrides in_valid and leaves the held block alone.
        bus0.blk_ready = 1'b0;
        sb.push_back({16{8'h77}});
        send_bytes(8'h77, 8'h00, 0, 15, 0);
        send_bytes(8'h40, 8'h01, 0, 6, 0);
        chk("clr_cnt7", 128'(bus0.byte_cnt), 128'd7);
        bus0.clear = 1'b1;
        send_byte(8'hEE);
        bus0.clear = 1'b0;
        chk("clr_cnt0", 128'(bus0.byte_cnt), 128'd0);
        chk("clr_hold", bus0.blk_out, {16{8'h77}});
        bus0.blk_ready = 1'b1;
        tick();
        chk("clr_accept", 128'(bus0.blk_valid), 128'd0);
        sb.push_back(vecs[0].exp_msb);
        send_bytes(vecs[0].base, vecs[0].step, 0, 15, 0);
        chk("clr_lsb_out", bus1.blk_out, vecs[0].exp_lsb);
        wait_drain();
        tick();

        // Asynchronous reset with a held block and a partial fill.
        bus0.blk_ready = 1'b0;
        sb.push_back({16{8'h5A}});
        send_bytes(8'h5A, 8'h00, 0, 15, 0);
        send_bytes(8'h90, 8'h01, 0, 4, 0);
        chk("ar_cnt5",  128'(bus0.byte_cnt),  128'd5);
        chk("ar_valid", 128'(bus0.blk_valid), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out0",   bus0.blk_out,          128'd0);
        chk("ar_valid0", 128'(bus0.blk_valid),  128'd0);
        chk("ar_cnt0",   128'(bus0.byte_cnt),   128'd0);
        chk("ar_ovf0",   128'(bus0.overflow),   128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_after_cnt", 128'(bus0.byte_cnt), 128'd0);

        chk("sb_empty",   128'(sb.size()), 128'd0);
        chk("ovf_total",  128'(ovf_seen),  128'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
